// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB master bridge and the SPI-side
// APB slave decoder (state encoding, bus width defaults, register map).
package apb_pkg;

  // Bus width defaults used by both the master and the slave decoder.
  localparam int APB_ADDR_W_DEF = 16;
  localparam int APB_DATA_W_DEF = 8;

  // Bridge FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  // SPI register map, word offsets carried in PADDR[5:2].
  // CMD (write side) and STATE (read side) share the last slot.
  localparam logic [3:0] APB_OFF_CONFIG = 4'd0;
  localparam logic [3:0] APB_OFF_TX     = 4'd1;
  localparam logic [3:0] APB_OFF_RX     = 4'd2;
  localparam logic [3:0] APB_OFF_CMD    = 4'd3;
  localparam logic [3:0] APB_OFF_STATE  = 4'd3;

  // Build a register address from a block base and a word offset.
  function automatic logic [APB_ADDR_W_DEF-1:0] apb_reg_addr(
    input logic [APB_ADDR_W_DEF-1:0] base,
    input logic [3:0]                off
  );
    return base | {10'd0, off, 2'b00};
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: 8-bit ACCESS-phase wait counter. Cleared when a transfer
// is accepted, counts cycles in which the slave is not ready, and flags the
// cycle in which the count would reach LIMIT while still not ready.
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_C = 8'(LIMIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This not-ready cycle is the LIMIT-th one: the transfer must abort.
  assign expired_o = en_i && (cnt_q == LAST_C);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB initiator. Converts a valid/ready
// command stream into SETUP/ACCESS transfers on PSEL0 and returns one
// response pulse per command (read data or write completion).
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYC not-ready cycles (response flagged with o_RSP_ERR).
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W_DEF,
  parameter int DATA_W      = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_PCLK,
  input  logic              i_PRESETn,
  input  logic              i_CMD_VALID,
  output logic              o_CMD_READY,
  input  logic              i_CMD_WRITE,
  input  logic [ADDR_W-1:0] i_CMD_ADDR,
  input  logic [DATA_W-1:0] i_CMD_WDATA,
  output logic              o_RSP_VALID,
  output logic [DATA_W-1:0] o_RSP_RDATA,
  output logic              o_RSP_ERR,
  output logic              o_PSEL0,
  output logic              o_PENABLE,
  output logic              o_PWRITE,
  output logic [ADDR_W-1:0] o_PADDR,
  output logic [DATA_W-1:0] o_PWDATA,
  input  logic [DATA_W-1:0] i_PRDATA,
  input  logic              i_PREADY
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_ready_s;
  logic              timeout_s;

  // Ready only from registered state, so there is no path from i_CMD_VALID.
  assign cmd_ready_s = (state_q == ST_IDLE) && !rsp_valid_q;

`ifdef APB_MASTER_TIMEOUT_EN
  logic timer_clear_s;
  logic timer_en_s;

  assign timer_clear_s = (state_q == ST_IDLE) && i_CMD_VALID && cmd_ready_s;
  assign timer_en_s    = (state_q == ST_ACCESS) && !i_PREADY;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk_i     (i_PCLK),
    .rst_ni    (i_PRESETn),
    .clear_i   (timer_clear_s),
    .en_i      (timer_en_s),
    .expired_o (timeout_s)
  );
`else
  logic [7:0] unused_timeout_cyc_s;

  assign unused_timeout_cyc_s = 8'(TIMEOUT_CYC);
  assign timeout_s            = 1'b0;
`endif

  // Next-state and next-output decode for the SETUP/ACCESS sequence.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (i_CMD_VALID && cmd_ready_s) begin
          paddr_d  = i_CMD_ADDR;
          pwrite_d = i_CMD_WRITE;
          if (i_CMD_WRITE) begin
            pwdata_d = i_CMD_WDATA;
          end else begin
            pwdata_d = '0;
          end
          psel_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // A ready slave takes precedence over a timeout in the same cycle.
        if (i_PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (pwrite_q) begin
            rsp_rdata_d = '0;
          end else begin
            rsp_rdata_d = i_PRDATA;
          end
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_IDLE;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          state_d   = ST_ACCESS;
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and registered bus/response outputs.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_CMD_READY = cmd_ready_s;
  assign o_PSEL0     = psel_q;
  assign o_PENABLE   = penable_q;
  assign o_PWRITE    = pwrite_q;
  assign o_PADDR     = paddr_q;
  assign o_PWDATA    = pwdata_q;
  assign o_RSP_VALID = rsp_valid_q;
  assign o_RSP_RDATA = rsp_rdata_q;
  assign o_RSP_ERR   = rsp_err_q;

endmodule
